// File: rtl/dmem_bridge.sv
// dmem_bridge: data memory for the single-cycle CPU datapath.
// Owns the storage array, absolute-address decode against BASE_ADDR, range and
// alignment checking, little-endian byte/half/word lanes, load extension and a
// programmable number of wait states. Requests use valid/ready; every accepted
// request produces exactly one single-cycle response pulse.
module dmem_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_sel,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  // Word-index width and the byte span covered by the array. The span is kept
  // 33 bits wide so the range compare stays correct for any legal depth.
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;
  localparam logic [1:0] SEL_ILL  = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SEL      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state;
  logic [3:0] wait_cnt;

  // Request fields captured at the accept edge; the requester may change its
  // inputs freely afterwards.
  logic             lat_we;
  logic [1:0]       lat_sel;
  logic             lat_signed;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_lane;
  logic [31:0]      lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      dec_off;
  logic             dec_in_range;
  logic [1:0]       dec_lane;
  logic [IDX_W-1:0] dec_idx;
  logic [1:0]       dec_err;

  logic [31:0] cur_word;
  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        commit;

  // Decode the live request: base-relative offset (addresses below the base wrap
  // to large values and fall out of range), word index, lane and error code.
  always_comb begin
    dec_off      = req_addr - BASE_ADDR;
    dec_in_range = ({1'b0, dec_off} < SPAN);
    dec_lane     = dec_off[1:0];
    dec_idx      = dec_off[IDX_W+1:2];
    if (req_sel == SEL_ILL) begin
      dec_err = ERR_SEL;
    end else if (!dec_in_range) begin
      dec_err = ERR_RANGE;
    end else if ((req_sel == SEL_WORD) && (dec_lane != 2'b00)) begin
      dec_err = ERR_MISALIGN;
    end else if ((req_sel == SEL_HALF) && dec_lane[0]) begin
      dec_err = ERR_MISALIGN;
    end else begin
      dec_err = ERR_OK;
    end
  end

  // Lane datapath for the latched request: extract and extend the load value and
  // merge store data into the current word so untouched lanes keep their bytes.
  always_comb begin
    cur_word   = mem[lat_idx];
    shifted    = cur_word >> {lat_lane, 3'b000};
    byte_val   = shifted[7:0];
    half_val   = lat_lane[1] ? cur_word[31:16] : cur_word[15:0];
    load_data  = '0;
    store_word = cur_word;
    case (lat_sel)
      SEL_WORD: begin
        load_data  = cur_word;
        store_word = lat_wdata;
      end
      SEL_HALF: begin
        load_data = lat_signed ? {{16{half_val[15]}}, half_val} : {16'h0000, half_val};
        store_word[{lat_lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
      end
      SEL_BYTE: begin
        load_data = lat_signed ? {{24{byte_val[7]}}, byte_val} : {24'h000000, byte_val};
        store_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
      end
      default: begin
        load_data  = '0;
        store_word = cur_word;
      end
    endcase
  end

  // The access happens on the last WAIT edge; only legal requests reach WAIT.
  assign commit = (state == ST_WAIT) && (wait_cnt == 4'd0);

  // Storage array: written only on the commit edge of a store and never cleared,
  // so a reset before commit simply drops the pending store.
  always_ff @(posedge clk) begin
    if (commit && lat_we) begin
      mem[lat_idx] <= store_word;
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      lat_we     <= 1'b0;
      lat_sel    <= SEL_WORD;
      lat_signed <= 1'b0;
      lat_idx    <= '0;
      lat_lane   <= 2'b00;
      lat_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          if (req_valid) begin
            lat_we     <= req_we;
            lat_sel    <= req_sel;
            lat_signed <= req_signed;
            lat_idx    <= dec_idx;
            lat_lane   <= dec_lane;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (dec_err != ERR_OK) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= dec_err;
              resp_rdata <= '0;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          req_ready <= 1'b0;
          if (wait_cnt == 4'd0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= lat_we ? 32'h0000_0000 : load_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= ERR_OK;
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed self-checking bench for dmem_bridge.
// Instance 0 is the default configuration (1024 words, one wait state);
// instances 1..3 use 16 words with 0, 3 and 15 wait states.
module tb_dmem_bridge;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam logic [1:0]  SEL_W = 2'b00;
  localparam logic [1:0]  SEL_H = 2'b01;
  localparam logic [1:0]  SEL_B = 2'b10;
  localparam logic [1:0]  SEL_X = 2'b11;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid  [4];
  logic        req_ready  [4];
  logic        req_we     [4];
  logic [1:0]  req_sel    [4];
  logic        req_signed [4];
  logic [31:0] req_addr   [4];
  logic [31:0] req_wdata  [4];
  logic        resp_valid [4];
  logic [31:0] resp_rdata [4];
  logic [1:0]  resp_err   [4];

  int checks = 0;
  int errors = 0;

  logic        got_resp;
  logic        got_after;
  logic [31:0] got_rdata;
  logic [1:0]  got_err;
  int          got_lat;

  int          resp_cyc [3];
  logic [31:0] resp_dat [3];
  int          k;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_bridge #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS((g == 0) ? 1024 : 16),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_sel   (req_sel[g]),
      .req_signed(req_signed[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 15;
  endfunction

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Park on a falling edge where the instance is ready to accept.
  task automatic wait_ready(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_ready", 32'(req_ready[d]), 32'd1);
  endtask

  // Issue one request, then measure cycles from the accept edge to the response
  // and sample the response one cycle later to confirm it is a single pulse.
  task automatic applyStimulus(input int d, input logic we, input logic [1:0] sel, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    wait_ready(d);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_sel[d]    = sel;
    req_signed[d] = sgn;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    got_resp  = 1'b0;
    got_after = 1'b0;
    got_rdata = '0;
    got_err   = 2'b00;
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    got_lat = n;
    if (resp_valid[d] === 1'b1) begin
      got_resp  = 1'b1;
      got_rdata = resp_rdata[d];
      got_err   = resp_err[d];
      @(posedge clk);
      #1;
      got_after = resp_valid[d];
    end
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                             input int exp_lat);
    checkOutput({tag, "_resp"}, 32'(got_resp), 32'd1);
    checkOutput({tag, "_rdata"}, got_rdata, exp_rdata);
    checkOutput({tag, "_err"}, 32'(got_err), 32'(exp_err));
    checkOutput({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
    checkOutput({tag, "_pulse"}, 32'(got_after), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_sel[i]    = SEL_W;
      req_signed[i] = 1'b0;
      req_addr[i]   = BASE;
      req_wdata[i]  = '0;
    end
    for (int i = 0; i < 3; i++) begin
      resp_cyc[i] = -100;
      resp_dat[i] = '0;
    end
    k = 0;

    // Power-on reset: outputs must take their reset values without a clock edge.
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("por_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("por_valid", 32'(resp_valid[0]), 32'd0);
    checkOutput("por_rdata", resp_rdata[0], 32'd0);
    checkOutput("por_err", 32'(resp_err[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Word round-trip with one wait state: response two cycles after accept.
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'h04, 32'hDEAD_BEEF);
    expect_resp("word_st", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE + 32'h04, 32'h0);
    expect_resp("word_ld", 32'hDEAD_BEEF, 2'b00, 2);

    // Byte and half lanes, little-endian.
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'h08, 32'h1122_3344);
    expect_resp("lane_st_w", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b1, SEL_B, 1'b0, BASE + 32'h0B, 32'h0000_0080);
    expect_resp("lane_st_b", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_W, 1'b1, BASE + 32'h08, 32'h0);
    expect_resp("lane_ld_w", 32'h8022_3344, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_B, 1'b1, BASE + 32'h0B, 32'h0);
    expect_resp("lane_ld_sb", 32'hFFFF_FF80, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_B, 1'b0, BASE + 32'h0B, 32'h0);
    expect_resp("lane_ld_ub", 32'h0000_0080, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_H, 1'b1, BASE + 32'h0A, 32'h0);
    expect_resp("lane_ld_sh", 32'hFFFF_8022, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_H, 1'b0, BASE + 32'h08, 32'h0);
    expect_resp("lane_ld_uh", 32'h0000_3344, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_B, 1'b1, BASE + 32'h09, 32'h0);
    expect_resp("lane_ld_sb_pos", 32'h0000_0033, 2'b00, 2);
    applyStimulus(0, 1'b1, SEL_H, 1'b0, BASE + 32'h08, 32'hABCD_5566);
    expect_resp("lane_st_h", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b1, SEL_B, 1'b0, BASE + 32'h09, 32'hFFFF_FF7E);
    expect_resp("lane_st_b1", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE + 32'h08, 32'h0);
    expect_resp("lane_ld_merge", 32'h8022_7E66, 2'b00, 2);

    // Errors: reported in the cycle after accept, rdata zero, memory untouched.
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE, 32'h0BAD_F00D);
    expect_resp("err_pre0", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'hFFC, 32'h0102_0304);
    expect_resp("err_pre1023", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b1, SEL_H, 1'b0, BASE + 32'h01, 32'hFFFF_FFFF);
    expect_resp("err_half_mis", 32'h0, 2'b01, 0);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE + 32'h02, 32'h0);
    expect_resp("err_word_mis_ld", 32'h0, 2'b01, 0);
    applyStimulus(0, 1'b1, SEL_W, 1'b0, 32'h1000_FFFC, 32'hFFFF_FFFF);
    expect_resp("err_below_base", 32'h0, 2'b10, 0);
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'h1000, 32'hFFFF_FFFF);
    expect_resp("err_past_end", 32'h0, 2'b10, 0);
    applyStimulus(0, 1'b1, SEL_X, 1'b0, BASE + 32'h03, 32'hFFFF_FFFF);
    expect_resp("err_sel", 32'h0, 2'b11, 0);
    applyStimulus(0, 1'b0, SEL_X, 1'b0, BASE + 32'h1000, 32'h0);
    expect_resp("err_sel_over_range", 32'h0, 2'b11, 0);
    applyStimulus(0, 1'b0, SEL_H, 1'b0, BASE + 32'h1001, 32'h0);
    expect_resp("err_range_over_mis", 32'h0, 2'b10, 0);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE, 32'h0);
    expect_resp("err_keep0", 32'h0BAD_F00D, 2'b00, 2);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE + 32'hFFC, 32'h0);
    expect_resp("err_keep1023", 32'h0102_0304, 2'b00, 2);

    // Reset in the middle of a pending store drops it without a response.
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'h10, 32'h1234_5678);
    expect_resp("rst_pre", 32'h0, 2'b00, 2);
    wait_ready(0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_sel[0]   = SEL_W;
    req_addr[0]  = BASE + 32'h10;
    req_wdata[0] = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    checkOutput("rst_accepted", 32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("rst_async_valid", 32'(resp_valid[0]), 32'd0);
    checkOutput("rst_async_rdata", resp_rdata[0], 32'd0);
    checkOutput("rst_async_err", 32'(resp_err[0]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_valid", 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rel_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("rst_rel_valid", 32'(resp_valid[0]), 32'd0);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE + 32'h10, 32'h0);
    expect_resp("rst_old_data", 32'h1234_5678, 2'b00, 2);

    // Handshake: inputs change while busy; only the accepted load is served.
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'h20, 32'hAAAA_0001);
    expect_resp("hs_pre_a", 32'h0, 2'b00, 2);
    applyStimulus(0, 1'b1, SEL_W, 1'b0, BASE + 32'h24, 32'hBBBB_0002);
    expect_resp("hs_pre_b", 32'h0, 2'b00, 2);
    wait_ready(0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_sel[0]   = SEL_W;
    req_addr[0]  = BASE + 32'h20;
    @(posedge clk);
    #1;
    checkOutput("hs_ready_w0", 32'(req_ready[0]), 32'd0);
    req_addr[0]  = BASE + 32'h24;
    req_we[0]    = 1'b1;
    req_wdata[0] = 32'h0;
    @(posedge clk);
    #1;
    checkOutput("hs_ready_w1", 32'(req_ready[0]), 32'd0);
    checkOutput("hs_valid_w1", 32'(resp_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("hs_resp_valid", 32'(resp_valid[0]), 32'd1);
    checkOutput("hs_resp_ready", 32'(req_ready[0]), 32'd0);
    checkOutput("hs_resp_rdata", resp_rdata[0], 32'hAAAA_0001);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hs_idle_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("hs_idle_valid", 32'(resp_valid[0]), 32'd0);
    applyStimulus(0, 1'b0, SEL_W, 1'b0, BASE + 32'h24, 32'h0);
    expect_resp("hs_b_intact", 32'hBBBB_0002, 2'b00, 2);

    // Back-to-back loads with zero wait states: one response every 3 cycles.
    applyStimulus(1, 1'b1, SEL_W, 1'b0, BASE + 32'h04, 32'h0000_0111);
    expect_resp("b2b_pre1", 32'h0, 2'b00, 1);
    applyStimulus(1, 1'b1, SEL_W, 1'b0, BASE + 32'h08, 32'h0000_0222);
    expect_resp("b2b_pre2", 32'h0, 2'b00, 1);
    applyStimulus(1, 1'b1, SEL_W, 1'b0, BASE + 32'h0C, 32'h0000_0333);
    expect_resp("b2b_pre3", 32'h0, 2'b00, 1);
    wait_ready(1);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_sel[1]   = SEL_W;
    req_addr[1]  = BASE + 32'h04;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid[1] === 1'b1) begin
        resp_cyc[k] = c;
        resp_dat[k] = resp_rdata[1];
        k++;
        req_addr[1] = BASE + 32'((k + 1) * 4);
        if (k == 3) req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    checkOutput("b2b_count", 32'(k), 32'd3);
    checkOutput("b2b_first", 32'(resp_cyc[0]), 32'd1);
    checkOutput("b2b_gap1", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
    checkOutput("b2b_gap2", 32'(resp_cyc[2] - resp_cyc[1]), 32'd3);
    checkOutput("b2b_dat0", resp_dat[0], 32'h0000_0111);
    checkOutput("b2b_dat1", resp_dat[1], 32'h0000_0222);
    checkOutput("b2b_dat2", resp_dat[2], 32'h0000_0333);

    // Small-array sweep: last word reachable, one past it out of range.
    for (int d = 1; d < 4; d++) begin
      applyStimulus(d, 1'b1, SEL_W, 1'b0, BASE, 32'h5A5A_0000 + 32'(d));
      expect_resp($sformatf("sweep%0d_st0", d), 32'h0, 2'b00, wait_of(d) + 1);
      applyStimulus(d, 1'b1, SEL_W, 1'b0, BASE + 32'h3C, 32'h0F0F_0000 + 32'(d));
      expect_resp($sformatf("sweep%0d_st15", d), 32'h0, 2'b00, wait_of(d) + 1);
      applyStimulus(d, 1'b0, SEL_W, 1'b0, BASE + 32'h3C, 32'h0);
      expect_resp($sformatf("sweep%0d_ld15", d), 32'h0F0F_0000 + 32'(d), 2'b00, wait_of(d) + 1);
      applyStimulus(d, 1'b1, SEL_W, 1'b0, BASE + 32'h40, 32'hFFFF_FFFF);
      expect_resp($sformatf("sweep%0d_st16", d), 32'h0, 2'b10, 0);
      applyStimulus(d, 1'b0, SEL_W, 1'b0, BASE, 32'h0);
      expect_resp($sformatf("sweep%0d_ld0", d), 32'h5A5A_0000 + 32'(d), 2'b00, wait_of(d) + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Parametrised data-memory block for the single-cycle CPU datapath; successor to the fixed 64-byte DMEM with external base subtraction.
- Owns the storage array, base-address decode, range check, byte/half/word lanes, load sign-extension and programmable wait states.
- Accesses use a valid/ready request and a response pulse, so slower memories can be modelled without changing the CPU.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address mapped to word 0.
- DEPTH_WORDS, 1024, number of 32-bit words (power of 2, ≥2).
- WAIT_CYCLES, 1, extra cycles between accept and commit (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_sel  input  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address, absolute (BASE_ADDR not pre-subtracted).
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result, valid while resp_valid is high.
- resp_err  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal sel.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, wait counter=0.
  - Storage array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, latch we/sel/signed/addr/wdata and compute the error code.
  - Error ≠ 00 → RESP. Otherwise → WAIT with counter=WAIT_CYCLES.
- WAIT:
  - req_ready=0.
  - If counter=0, perform the access this edge and go to RESP. Otherwise decrement the counter.
  - With WAIT_CYCLES=0, WAIT lasts exactly one cycle.
- RESP:
  - req_ready=0, resp_valid=1 for exactly one cycle, then → IDLE.
  - No backpressure on the response.
- Latency:
  - Legal access: accept edge to resp_valid high = WAIT_CYCLES+1 cycles.
  - Errored access: resp_valid high 1 cycle after the accept edge.
  - Maximum throughput is one request per WAIT_CYCLES+3 cycles.
- Decode:
  - off = req_addr − BASE_ADDR, 32-bit unsigned, so addresses below BASE_ADDR wrap to large values.
  - In range iff off < DEPTH_WORDS*4. Word index = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
- Error priority: sel=11 → 11; else out of range → 10; else misaligned → 01.
  - Word is misaligned when lane≠00; half is misaligned when lane[0]=1.
  - An errored store never writes memory; an errored response returns resp_rdata=0.
- Stores (little-endian):
  - Byte writes req_wdata[7:0] to bits [8*lane+7:8*lane].
  - Half writes [15:0] to bits [16*lane[1]+15:16*lane[1]].
  - Word writes all 32 bits.
  - Other lanes are unchanged. Memory is written only at the commit edge (end of WAIT).
  - Store response: resp_rdata=0, resp_err=00.
- Loads:
  - The word is read at the commit edge and the selected lane is extracted.
  - Byte/half: sign-extend if req_signed=1, else zero-fill. Word: req_signed is ignored.
- Request inputs are sampled only at the accept edge; later changes during WAIT/RESP have no effect.
- Reset mid-operation:
  - A pending store not yet committed is dropped (memory unchanged); no response is issued.
  - After reset release the FSM is in IDLE with req_ready=1.
- req_valid while req_ready=0 is ignored, not queued; the requester must hold it until accepted.

Test Plan:
- Reset/idle: rst=0 mid-WAIT of a pending word store to 0x1001_0010 → outputs at reset values immediately (async); after release, a load of 0x1001_0010 returns the old contents.
- Word round-trip: store 0xDEADBEEF to 0x1001_0004, then load word → resp_rdata=0xDEADBEEF, err=00. With WAIT_CYCLES=1, resp_valid rises 2 cycles after each accept edge.
- Byte/half lanes: store word 0x11223344 to 0x1001_0008, then store byte 0x80 to 0x1001_000B:
  - Word load → 0x80223344.
  - Signed byte load of 0x…0B → 0xFFFFFF80; unsigned → 0x00000080.
  - Signed half load of 0x…0A → 0xFFFF8022.
- Errors: each case must leave memory unchanged and report in 1 cycle.
  - Half at 0x1001_0001 → err=01.
  - Word at 0x1000_FFFC → err=10.
  - Word at BASE_ADDR+DEPTH_WORDS*4 → err=10.
  - sel=11 at an in-range, misaligned address → err=11.
- Handshake: hold req_valid high with changing addr during WAIT → only the accepted request is served, and req_ready is low from accept through RESP. With WAIT_CYCLES=0 and 3 back-to-back loads → responses every 3 cycles.
- Parameter sweep: DEPTH_WORDS=16 with WAIT_CYCLES ∈ {0,3,15} → word 15 accessible, word 16 → err=10, latency = WAIT_CYCLES+1 cycles.
